// File: rtl/arduino_tx_if.sv
// Bus between the game logic and the Arduino serial transmitter.
// send acts as valid: a word transfers on a rising clock edge with send && ready; send while ready=0 is dropped.
interface arduino_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  send;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;
  logic                  arduinoClockOut;
  logic                  arduinoData;
  logic                  arduinoFrame;
  logic [2:0]            fsm_state;

  modport master (
    output send, data,
    input  ready, arduinoClockOut, arduinoData, arduinoFrame, fsm_state
  );

  modport slave (
    input  send, data,
    output ready, arduinoClockOut, arduinoData, arduinoFrame, fsm_state
  );
endinterface

// File: rtl/arduino_tx.sv
// FPGA-to-Arduino three-wire serial transmitter: START slot, MSB-first data slots, optional parity slot, GAP slot.
// Define ARDUINO_TX_PARITY_EN to append an even-parity slot after the LSB.
module arduino_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 10
) (
  input  logic        clock,
  input  logic        reset,
  arduino_tx_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3
`ifdef ARDUINO_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  half;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ready;
  logic                  sclk;
  logic                  sdata;
  logic                  frame;
  logic                  tick;
  logic                  clocked_slot;
`ifdef ARDUINO_TX_PARITY_EN
  logic                  parity;
`endif

  assign tick = (cnt == CW'(CLK_DIV - 1));
`ifdef ARDUINO_TX_PARITY_EN
  assign clocked_slot = (state == SHIFT) || (state == PARITY);
`else
  assign clocked_slot = (state == SHIFT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      half    <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      frame   <= 1'b0;
`ifdef ARDUINO_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      cnt  <= '0;
      half <= 1'b0;
      if (bus.send) begin
        shreg <= bus.data;
        state <= START;
        ready <= 1'b0;
        frame <= 1'b1;
`ifdef ARDUINO_TX_PARITY_EN
        parity <= ^bus.data;
`endif
      end
    end else if (!tick) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
      if (!half) begin
        // START and GAP keep the serial clock low for both halves
        half <= 1'b1;
        sclk <= clocked_slot;
      end else begin
        half <= 1'b0;
        sclk <= 1'b0;
        case (state)
          START: begin
            state   <= SHIFT;
            bit_idx <= BW'(DATA_WIDTH - 1);
            sdata   <= shreg[DATA_WIDTH-1];
            shreg   <= shreg << 1;
          end
          SHIFT: begin
            if (bit_idx == '0) begin
`ifdef ARDUINO_TX_PARITY_EN
              state <= PARITY;
              sdata <= parity;
`else
              state <= GAP;
              sdata <= 1'b0;
              frame <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx - BW'(1);
              sdata   <= shreg[DATA_WIDTH-1];
              shreg   <= shreg << 1;
            end
          end
`ifdef ARDUINO_TX_PARITY_EN
          PARITY: begin
            state <= GAP;
            sdata <= 1'b0;
            frame <= 1'b0;
          end
`endif
          GAP: begin
            state <= IDLE;
            ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ready           = ready;
  assign bus.arduinoClockOut = sclk;
  assign bus.arduinoData     = sdata;
  assign bus.arduinoFrame    = frame;
  assign bus.fsm_state       = state;
endmodule

// File: tb/tb_arduino_tx.sv
// Self-checking bench for arduino_tx: random words against a bit-level frame model with timing from the frame formulas.
// Follows ARDUINO_TX_PARITY_EN so the model matches the build under test.
module tb_arduino_tx;
  localparam int DW = 16;
  localparam int CD = 10;
`ifdef ARDUINO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int READY_LAT = 2 * (DW + P + 2) * CD;
  localparam int FALL_LAT  = 2 * (DW + P + 1) * CD;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  arduino_tx_if #(.DATA_WIDTH(DW)) bus ();

  arduino_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // scoreboard state: expected serial bits and observed events
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int rise_q[$];
  int accept_q[$];
  int ready_q[$];
  int fall_q[$];
  int bad_edge = 0;
  int stray_rise = 0;
  logic p_sclk = 1'b0, p_data = 1'b0, p_ready = 1'b1, p_frame = 1'b0;

  always @(negedge clock) begin
    if (!p_sclk && bus.arduinoClockOut) begin
      got_q.push_back(bus.arduinoData);
      rise_q.push_back(cyc);
      if (!bus.arduinoFrame) stray_rise <= stray_rise + 1;
    end
    if (bus.arduinoData !== p_data && bus.arduinoClockOut) bad_edge <= bad_edge + 1;
    if (p_ready && !bus.ready) accept_q.push_back(cyc);
    if (!p_ready && bus.ready) ready_q.push_back(cyc);
    if (p_frame && !bus.arduinoFrame) fall_q.push_back(cyc);
    p_sclk  <= bus.arduinoClockOut;
    p_data  <= bus.arduinoData;
    p_ready <= bus.ready;
    p_frame <= bus.arduinoFrame;
  end

  // reference model: MSB-first data bits, then the bit that makes the total count of ones even
  task automatic model_push(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (P == 1) exp_q.push_back(1'($countones(d) % 2));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    rise_q.delete();
    accept_q.delete();
    ready_q.delete();
    fall_q.delete();
  endtask

  // drivers
  task automatic drive_word(input logic [DW-1:0] d);
    for (int i = 0; i < 1000 && bus.ready !== 1'b1; i++) @(negedge clock);
    bus.data = d;
    bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input int n, input string name);
    for (int i = 0; i < 2000 && ready_q.size() < n; i++) begin
      @(negedge clock);
      #1;
    end
    vectors++;
    if (ready_q.size() < n) begin
      miscompares++;
      $display("FAIL %s ready_timeout: saw %0d ready rises, expected %0d", name, ready_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if ({bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame} !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset_held: outputs %b expected 1000", {bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      vectors++;
      if ({bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame} !== 4'b1000) begin
        miscompares++;
        $display("FAIL idle_after_reset cycle %0d: outputs %b expected 1000", i, {bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame});
      end
    end
  endtask

  task automatic test_frames();
    logic [DW-1:0] words[8];
    int k, r, f, be0, sr0;
    words[0] = 16'hA5C3;
    words[1] = 16'h0001;
    words[2] = 16'hFFFF;
    words[3] = 16'h0000;
    for (int w = 4; w < 8; w++) words[w] = DW'($urandom);
    for (int w = 0; w < 8; w++) begin
      be0 = bad_edge;
      sr0 = stray_rise;
      clear_sb();
      model_push(words[w]);
      drive_word(words[w]);
      wait_ready(1, "frames");
      vectors++;
      if (accept_q.size() != 1) begin
        miscompares++;
        $display("FAIL frames accept_count word %h: got %0d expected 1", words[w], accept_q.size());
      end
      k = (accept_q.size() > 0) ? accept_q[0] : 0;
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL frames bit_count word %h: got %0d expected %0d", words[w], got_q.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
        vectors++;
        if (got_q[j] !== exp_q[j]) begin
          miscompares++;
          $display("FAIL frames bit word %h slot %0d: got %b expected %b", words[w], j, got_q[j], exp_q[j]);
        end
      end
      for (int j = 0; j < rise_q.size() && j < DW + P; j++) begin
        vectors++;
        if (rise_q[j] - k != (2 * j + 3) * CD) begin
          miscompares++;
          $display("FAIL frames rise_time word %h slot %0d: got %0d expected %0d", words[w], j, rise_q[j] - k, (2 * j + 3) * CD);
        end
      end
      r = (ready_q.size() > 0) ? ready_q[0] - k : -1;
      vectors++;
      if (r != READY_LAT) begin
        miscompares++;
        $display("FAIL frames ready_latency word %h: got %0d expected %0d", words[w], r, READY_LAT);
      end
      f = (fall_q.size() > 0) ? fall_q[0] - k : -1;
      vectors++;
      if (f != FALL_LAT) begin
        miscompares++;
        $display("FAIL frames frame_fall word %h: got %0d expected %0d", words[w], f, FALL_LAT);
      end
      vectors++;
      if (bad_edge != be0 || stray_rise != sr0) begin
        miscompares++;
        $display("FAIL frames serial_protocol word %h: got %0d bad edges %0d stray rises, expected 0 0", words[w], bad_edge - be0, stray_rise - sr0);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [DW-1:0] d0;
    int r;
    d0 = DW'($urandom);
    clear_sb();
    model_push(d0);
    drive_word(d0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      bus.data = DW'($urandom);
      bus.send = ($urandom_range(0, 7) == 0);
    end
    bus.send = 1'b0;
    wait_ready(1, "ignored");
    repeat (400) @(negedge clock);
    #1;
    vectors++;
    if (accept_q.size() != 1) begin
      miscompares++;
      $display("FAIL ignored accept_count: got %0d expected 1", accept_q.size());
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ignored bit_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL ignored bit slot %0d: got %b expected %b", j, got_q[j], exp_q[j]);
      end
    end
    r = (ready_q.size() > 0 && accept_q.size() > 0) ? ready_q[0] - accept_q[0] : -1;
    vectors++;
    if (r != READY_LAT) begin
      miscompares++;
      $display("FAIL ignored ready_latency: got %0d expected %0d", r, READY_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[3];
    int g, r;
    for (int n = 0; n < 3; n++) w[n] = DW'($urandom);
    clear_sb();
    for (int n = 0; n < 3; n++) model_push(w[n]);
    for (int i = 0; i < 1000 && bus.ready !== 1'b1; i++) @(negedge clock);
    bus.data = w[0];
    bus.send = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 1000 && accept_q.size() <= n; i++) begin
        @(negedge clock);
        #1;
      end
      if (n < 2) bus.data = w[n + 1];
      else bus.send = 1'b0;
    end
    wait_ready(3, "b2b");
    vectors++;
    if (accept_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b accept_count: got %0d expected 3", accept_q.size());
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b bit_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL b2b bit slot %0d: got %b expected %b", j, got_q[j], exp_q[j]);
      end
    end
    for (int n = 0; n < 2; n++) begin
      g = (accept_q.size() > n + 1 && fall_q.size() > n) ? accept_q[n + 1] - fall_q[n] : -1;
      vectors++;
      if (g != 2 * CD + 1) begin
        miscompares++;
        $display("FAIL b2b frame_gap %0d: got %0d expected %0d", n, g, 2 * CD + 1);
      end
    end
    for (int n = 0; n < 3; n++) begin
      r = (ready_q.size() > n && accept_q.size() > n) ? ready_q[n] - accept_q[n] : -1;
      vectors++;
      if (r != READY_LAT) begin
        miscompares++;
        $display("FAIL b2b ready_latency %0d: got %0d expected %0d", n, r, READY_LAT);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k, r;
    clear_sb();
    drive_word(DW'($urandom));
    k = (accept_q.size() > 0) ? accept_q[0] : cyc;
    for (int i = 0; i < 400 && cyc < k + 150; i++) @(negedge clock);
    vectors++;
    if (bus.arduinoFrame !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame active: frame %b expected 1", bus.arduinoFrame);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame} !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_frame async_reset: outputs %b expected 1000", {bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame});
    end
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if ({bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame} !== 4'b1000) begin
        miscompares++;
        $display("FAIL mid_frame reset_held: outputs %b expected 1000", {bus.ready, bus.arduinoClockOut, bus.arduinoData, bus.arduinoFrame});
      end
    end
    reset = 1'b0;
    @(negedge clock);
    clear_sb();
    model_push(16'h1234);
    drive_word(16'h1234);
    wait_ready(1, "post_reset");
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL post_reset bit_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL post_reset bit slot %0d: got %b expected %b", j, got_q[j], exp_q[j]);
      end
    end
    r = (ready_q.size() > 0 && accept_q.size() > 0) ? ready_q[0] - accept_q[0] : -1;
    vectors++;
    if (r != READY_LAT) begin
      miscompares++;
      $display("FAIL post_reset ready_latency: got %0d expected %0d", r, READY_LAT);
    end
  endtask

  initial begin
    reset    = 1'b0;
    bus.send = 1'b0;
    bus.data = '0;
    #1;
    reset = 1'b1;
    test_reset();
    test_frames();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
